// File: rtl/dist_ram_fifo_ctrl.sv
// First-word-fall-through FIFO controller around an external simple dual-port
// distributed RAM (sync write, async read) with a registered output stage.
//
// Handshake: a word moves on a side only in a cycle where valid and ready are
// both high at the rising edge; valid never waits on ready, and a valid word
// with its data stays stable until it is taken.
module dist_ram_fifo_ctrl #(
  parameter int WIDTH      = 64,
  parameter int ADDR_WIDTH = 6,
  parameter int DEPTH      = 1 << ADDR_WIDTH,
  parameter int AFULL_THR  = DEPTH - 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  input  logic                  out_ready,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_addr_a,
  output logic [WIDTH-1:0]      ram_d_in,
  output logic [ADDR_WIDTH-1:0] ram_addr_b,
  input  logic [WIDTH-1:0]      ram_d_out
);

  localparam logic [ADDR_WIDTH:0] AFULL_THR_C = (ADDR_WIDTH + 1)'(AFULL_THR);

  logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
  logic                out_valid_q, out_valid_d;
  logic [WIDTH-1:0]    out_data_q, out_data_d;

  logic [ADDR_WIDTH:0] ram_count;
  logic                ram_empty;
  logic                ram_full;
  logic                push;
  logic                load;

  // Pointer MSB is a wrap flag so full and empty are distinguishable.
  assign ram_count = wr_ptr_q - rd_ptr_q;
  assign ram_empty = (wr_ptr_q == rd_ptr_q);
  assign ram_full  = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]) &&
                     (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);

  assign in_ready = !ram_full;
  assign push     = in_valid && in_ready && rst_n;
  assign load     = !ram_empty && (!out_valid_q || out_ready);

  assign ram_wr_en   = push;
  assign ram_addr_a  = wr_ptr_q[ADDR_WIDTH-1:0];
  assign ram_d_in    = in_data;
  assign ram_addr_b  = rd_ptr_q[ADDR_WIDTH-1:0];

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign count       = ram_count + {{ADDR_WIDTH{1'b0}}, out_valid_q};
  assign almost_full = (ram_count >= AFULL_THR_C);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    // Refill the output stage from the RAM head whenever it is free or draining.
    if (load) begin
      out_data_d  = ram_d_out;
      out_valid_d = 1'b1;
      rd_ptr_d    = rd_ptr_q + 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule

// File: tb/tb_dist_ram_fifo_ctrl.sv
// Bench for dist_ram_fifo_ctrl: behavioural distributed RAM, occupancy model
// and an expected-data queue checked against the output stage.
module tb_dist_ram_fifo_ctrl;
  localparam int W  = 64;
  localparam int AW = 6;
  localparam int D  = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          out_ready;
  logic          almost_full;
  logic [AW:0]   count;
  logic          ram_wr_en;
  logic [AW-1:0] ram_addr_a;
  logic [W-1:0]  ram_d_in;
  logic [AW-1:0] ram_addr_b;
  logic [W-1:0]  ram_d_out;

  // clock / reset
  always #5 clk = ~clk;

  dist_ram_fifo_ctrl #(.WIDTH(W), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .almost_full(almost_full), .count(count),
    .ram_wr_en(ram_wr_en), .ram_addr_a(ram_addr_a), .ram_d_in(ram_d_in),
    .ram_addr_b(ram_addr_b), .ram_d_out(ram_d_out)
  );

  // external RAM: synchronous write, asynchronous read
  logic [W-1:0] mem [D];
  always @(posedge clk) if (ram_wr_en) mem[ram_addr_a] <= ram_d_in;
  assign ram_d_out = mem[ram_addr_b];

  // scoreboard and model state
  int           checks = 0;
  int           errors = 0;
  int           pops   = 0;
  logic [W-1:0] exp_q[$];
  logic [AW:0]  m_wr, m_rd;
  logic         m_ov;

  task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_wr = '0;
    m_rd = '0;
    m_ov = 1'b0;
  endtask

  // Driver: called just after a rising edge; drives, checks mid-cycle, advances.
  task automatic cycle(input logic iv, input logic [W-1:0] id, input logic ordy);
    logic [AW:0] ram_n;
    logic        full, empty, push, load;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    #1;
    ram_n = m_wr - m_rd;
    full  = (ram_n == D[AW:0]);
    empty = (ram_n == '0);
    push  = iv && !full;
    load  = !empty && (!m_ov || ordy);
    check("in_ready",    in_ready,    !full);
    check("count",       count,       ram_n + m_ov);
    check("almost_full", almost_full, ram_n >= D - 4);
    check("out_valid",   out_valid,   m_ov);
    check("ram_wr_en",   ram_wr_en,   push);
    check("ram_addr_a",  ram_addr_a,  m_wr[AW-1:0]);
    check("ram_addr_b",  ram_addr_b,  m_rd[AW-1:0]);
    if (push) check("ram_d_in", ram_d_in, id);
    if (push && load) check("addr_overlap", ram_addr_a == ram_addr_b, 1'b0);
    if (m_ov) begin
      check("sb_nonempty", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) check("out_data", out_data, exp_q[0]);
    end
    if (m_ov && ordy && exp_q.size() > 0) begin
      void'(exp_q.pop_front());
      pops++;
    end
    if (push) exp_q.push_back(id);
    m_wr = m_wr + {{AW{1'b0}}, push};
    m_rd = m_rd + {{AW{1'b0}}, load};
    if (load) m_ov = 1'b1;
    else if (m_ov && ordy) m_ov = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int s_pops;
    // reset held with a producer already requesting
    rst_n = 1'b0; in_valid = 1'b1; in_data = 64'h55; out_ready = 1'b0;
    model_reset();
    #12;
    check("rst_in_ready",  in_ready,  1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_count",     count,     '0);
    check("rst_wr_en",     ram_wr_en, 1'b0);
    check("rst_afull",     almost_full, 1'b0);
    #1 rst_n = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;

    // single word, held under backpressure then taken
    cycle(1'b1, 64'hA5, 1'b0);
    cycle(1'b0, '0, 1'b0);
    check("single_valid", out_valid, 1'b1);
    check("single_data",  out_data,  64'hA5);
    check("single_count", count,     7'd1);
    repeat (5) cycle(1'b0, '0, 1'b0);
    check("single_hold", out_data, 64'hA5);
    cycle(1'b0, '0, 1'b1);
    check("single_gone",  out_valid, 1'b0);
    check("single_empty", count,     '0);

    // fill to capacity; last word waits for a pop and one extra cycle
    for (int i = 0; i < 66; i++) cycle(1'b1, W'(i), 1'b0);
    check("fill_count", count,       7'd65);
    check("fill_ready", in_ready,    1'b0);
    check("fill_afull", almost_full, 1'b1);
    cycle(1'b1, 64'd65, 1'b1);
    check("fill_blocked", in_ready, 1'b1);
    cycle(1'b1, 64'd65, 1'b0);
    repeat (70) cycle(1'b0, '0, 1'b1);
    check("fill_drained", exp_q.size(), 0);

    // streaming across several pointer wraps
    s_pops = pops;
    for (int i = 0; i < 200; i++) cycle(1'b1, W'(i), 1'b1);
    repeat (4) cycle(1'b0, '0, 1'b1);
    check("stream_pops", pops - s_pops, 200);

    // random traffic on both sides
    repeat (5000) cycle(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 1)));
    repeat (70) cycle(1'b0, '0, 1'b1);
    check("rand_drained", exp_q.size(), 0);
    check("rand_count",   count,        '0);

    // asynchronous reset in the middle of a cycle
    for (int i = 0; i < 10; i++) cycle(1'b1, W'(100 + i), 1'b0);
    check("pre_rst_count", count, 7'd10);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid,   1'b0);
    check("arst_count",     count,       '0);
    check("arst_in_ready",  in_ready,    1'b1);
    check("arst_out_data",  out_data,    '0);
    check("arst_afull",     almost_full, 1'b0);
    model_reset();
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    cycle(1'b1, 64'h3C, 1'b0);
    cycle(1'b0, '0, 1'b0);
    check("post_rst_data",  out_data, 64'h3C);
    check("post_rst_count", count,    7'd1);
    cycle(1'b0, '0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
